// File: rtl/parity_frame_unit.sv
// Frame parity generator/checker: accumulates FRAME_LEN data words, then compares a received parity beat.
// Optional saturating error counter is enabled by defining PARITY_ERR_CNT_EN.
module parity_frame_unit #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ACC = 2'd0,
    CHK = 2'd1,
    RSP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              acc;
  logic              mode_q;
  logic              frame_par;
  logic              in_fire;
  logic              data_fire;
  logic              chk_fire;
  logic              out_fire;
  logic              last_beat;
  logic              chk_mismatch;

  assign in_fire      = in_valid & in_ready;
  assign data_fire    = in_fire & (state == ACC);
  assign chk_fire     = in_fire & (state == CHK);
  assign out_fire     = out_valid & out_ready;
  assign last_beat    = (beat_cnt == LAST_BEAT);
  assign frame_par    = acc ^ mode_q;
  assign chk_mismatch = in_data[0] ^ frame_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) begin
          state_nxt = CHK;
        end
      end
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RSP;
        end
      end
      RSP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACC;
        end
      end
      default: begin
        state_nxt = ACC;
      end
    endcase
  end

  // Mode is sampled only on the first data beat so mid-frame changes cannot corrupt the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 1'b0;
      beat_cnt   <= '0;
      mode_q     <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      if (data_fire) begin
        acc      <= acc ^ (^in_data);
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        if (beat_cnt == '0) begin
          mode_q <= mode;
        end
      end
      if (chk_fire) begin
        out_parity <= frame_par;
        out_err    <= chk_mismatch;
      end
      if (out_fire) begin
        acc <= 1'b0;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  // Counts frames entering RSP with a mismatch; a clear request overrides the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (clr_cnt) begin
      err_cnt_q <= '0;
    end else if (chk_fire && chk_mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_clr_cnt;

  assign unused_clr_cnt = clr_cnt;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_parity_frame_unit.sv
// Directed, table-driven bench for parity_frame_unit (DATA_W=8, FRAME_LEN=4, CNT_W=2).
// err_count expectations follow PARITY_ERR_CNT_EN when it is defined for the whole build.
module tb_parity_frame_unit;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;
`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_parity;
  logic              out_err;
  logic              clr_cnt;
  logic [CNT_W-1:0]  err_count;

  int checks;
  int errors;
  int exp_cnt;

  typedef struct {
    logic        m;
    logic        tog;
    logic [31:0] data;
    logic [7:0]  chk;
    logic        par;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  parity_frame_unit #(
    .DATA_W(DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_parity(out_parity),
    .out_err(out_err),
    .clr_cnt(clr_cnt),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int expCount();
    return CNT_EN ? exp_cnt : 0;
  endfunction

  function automatic void bumpModel(input logic err, input logic clr);
    if (clr) exp_cnt = 0;
    else if (err && exp_cnt < 3) exp_cnt = exp_cnt + 1;
  endfunction

  // Offers one beat and returns just after the rising edge that accepted it.
  task automatic sendBeat(input logic [7:0] d, input logic m, input logic clr);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    mode     = m;
    clr_cnt  = clr;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("beat_accept_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic applyStimulus(input logic m, input logic tog, input logic [31:0] data,
                               input logic [7:0] chk, input logic clr);
    logic [7:0] b;
    for (int i = 0; i < FRAME_LEN; i++) begin
      b = data[31-8*i -: 8];
      sendBeat(b, (i > 0 && tog) ? ~m : m, 1'b0);
    end
    checkOutput("valid_before_check", 32'(out_valid), 32'd0);
    sendBeat(chk, m, clr);
  endtask

  task automatic checkResult(input logic par, input logic err);
    checkOutput("out_valid_latency1", 32'(out_valid), 32'd1);
    checkOutput("out_parity", 32'(out_parity), 32'(par));
    checkOutput("out_err", 32'(out_err), 32'(err));
    checkOutput("err_count", 32'(err_count), 32'(expCount()));
  endtask

  task automatic takeResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("valid_after_take", 32'(out_valid), 32'd0);
    checkOutput("ready_after_take", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_cnt   = 1'b0;

    vecs[0] = '{m: 1'b0, tog: 1'b0, data: 32'h01000000, chk: 8'h01, par: 1'b1, err: 1'b0};
    vecs[1] = '{m: 1'b1, tog: 1'b0, data: 32'h01000000, chk: 8'h01, par: 1'b0, err: 1'b1};
    vecs[2] = '{m: 1'b0, tog: 1'b0, data: 32'h03000000, chk: 8'h00, par: 1'b0, err: 1'b0};
    vecs[3] = '{m: 1'b1, tog: 1'b0, data: 32'hFF0F0100, chk: 8'h00, par: 1'b0, err: 1'b0};
    vecs[4] = '{m: 1'b0, tog: 1'b1, data: 32'h07000000, chk: 8'h01, par: 1'b1, err: 1'b0};
    vecs[5] = '{m: 1'b1, tog: 1'b1, data: 32'h00000000, chk: 8'h01, par: 1'b1, err: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_parity", 32'(out_parity), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].m, vecs[v].tog, vecs[v].data, vecs[v].chk, 1'b0);
      bumpModel(vecs[v].err, 1'b0);
      checkResult(vecs[v].par, vecs[v].err);
      takeResult();
    end

    // Clear, then saturate with four erroneous frames and clear on a fifth error entry.
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    bumpModel(1'b0, 1'b1);
    checkOutput("clr_cnt_idle", 32'(err_count), 32'(expCount()));
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 32'h00000000, 8'h01, (k == 4));
      bumpModel(1'b1, (k == 4));
      checkResult(1'b0, 1'b1);
      takeResult();
    end

    // Back-pressure in RSP: outputs hold and offered beats are not taken.
    applyStimulus(1'b0, 1'b0, 32'h01000000, 8'h00, 1'b0);
    bumpModel(1'b1, 1'b0);
    checkResult(1'b1, 1'b1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_parity", 32'(out_parity), 32'd1);
      checkOutput("stall_err", 32'(out_err), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    takeResult();
    applyStimulus(1'b0, 1'b0, 32'h01000000, 8'h01, 1'b0);
    bumpModel(1'b0, 1'b0);
    checkResult(1'b1, 1'b0);
    takeResult();

    // Leave an erroneous result behind, then reset in the middle of a frame.
    applyStimulus(1'b1, 1'b0, 32'h01000000, 8'h01, 1'b0);
    bumpModel(1'b1, 1'b0);
    checkResult(1'b0, 1'b1);
    takeResult();
    sendBeat(8'hFF, 1'b0, 1'b0);
    sendBeat(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_parity", 32'(out_parity), 32'd0);
    checkOutput("async_rst_err", 32'(out_err), 32'd0);
    checkOutput("async_rst_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'hFFFFFF80, 8'h01, 1'b0);
    checkResult(1'b1, 1'b0);
    takeResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_unit.md
PARITY_FRAME_UNIT -- requirements
Module: parity_frame_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, meaning data word width in bits (legal range 1..64).
REQ-002 SHALL provide parameter FRAME_LEN, default 4, meaning data words per frame (legal range 1..256).
REQ-003 SHALL provide parameter CNT_W, default 8, meaning error counter width.
REQ-004 SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL provide port mode, input, 1 bit: 0 = even parity, 1 = odd parity.
REQ-007 SHALL provide port in_valid, input, 1 bit: input beat valid.
REQ-008 SHALL provide port in_ready, output, 1 bit: block accepts a beat.
REQ-009 SHALL provide port in_data, input, DATA_W bits: data word, or received parity in bit 0 on the check beat.
REQ-010 SHALL provide port out_valid, output, 1 bit: frame result valid.
REQ-011 SHALL provide port out_ready, input, 1 bit: consumer takes the result.
REQ-012 SHALL provide port out_parity, output, 1 bit: computed parity bit of the frame.
REQ-013 SHALL provide port out_err, output, 1 bit: received parity differs from out_parity.
REQ-014 SHALL provide port clr_cnt, input, 1 bit: synchronous clear of the error counter.
REQ-015 SHALL provide port err_count, output, CNT_W bits: count of erroneous frames.

Function
REQ-016 SHALL accept a beat only when in_valid and in_ready are both 1 in the same cycle.
REQ-017 SHALL implement states ACC (data beats), CHK (one parity beat) and RSP (result held).
REQ-018 SHALL drive in_ready = 1 in ACC and CHK, and in_ready = 0 in RSP.
REQ-019 SHALL, in ACC, XOR-reduce each accepted word into a running accumulator and increment the beat counter.
REQ-020 SHALL go ACC->CHK on acceptance of data beat FRAME_LEN; beat counter wraps to 0.
REQ-021 SHALL latch mode on the first accepted data beat of a frame and ignore mode changes for the rest of that frame.
REQ-022 SHALL compute out_parity = accumulator XOR latched mode, so that the frame ones count plus out_parity is even (mode 0) or odd (mode 1).
REQ-023 SHALL, in CHK, on acceptance compare in_data[0] against the computed parity, register out_err, and go CHK->RSP.
REQ-024 SHALL assert out_valid in RSP only, starting the cycle after the check beat is accepted (latency 1).
REQ-025 SHALL hold out_parity and out_err stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL go RSP->ACC on out_valid and out_ready, clear the accumulator, and make in_ready = 1 in the next cycle.
REQ-027 SHALL treat FRAME_LEN = 1 as ACC->CHK after a single data beat.
REQ-028 SHALL ignore in_data and in_valid while in RSP; beats are neither consumed nor lost.

Reset
REQ-029 SHALL, on rst_n = 0, immediately set state ACC, accumulator 0, beat counter 0, latched mode 0, out_valid 0, out_parity 0, out_err 0 and err_count 0.
REQ-030 SHALL discard a partial frame when reset is asserted mid-frame; the first beat after release starts a new frame.

Configuration
REQ-031 SHALL, with macro PARITY_ERR_CNT_EN defined, increment err_count by 1 on entry to RSP with out_err = 1, saturating at 2^CNT_W-1.
REQ-032 SHALL, with PARITY_ERR_CNT_EN defined, clear err_count when clr_cnt = 1, with clear winning over a simultaneous increment.
REQ-033 SHALL, without PARITY_ERR_CNT_EN, tie err_count to 0, ignore clr_cnt, and implement no counter flops.

Verification (DATA_W=8, FRAME_LEN=4, CNT_W=2, macro defined)
REQ-034 SHALL cover: mode=0, data 0x01,0x00,0x00,0x00, parity beat 0x01 -> out_parity=1, out_err=0, out_valid one cycle after the check beat.
REQ-035 SHALL cover: mode=1 with the same data, parity beat 0x01 -> out_parity=0, out_err=1, err_count=1.
REQ-036 SHALL cover: out_ready=0 for 5 cycles in RSP -> out_valid, out_parity and out_err stable, in_ready=0, offered beats not consumed.
REQ-037 SHALL cover: four consecutive erroneous frames -> err_count 1,2,3,3 (saturated); then clr_cnt=1 coincident with a fifth error entry -> err_count=0.
REQ-038 SHALL cover: rst_n low after 2 data beats -> all outputs 0 asynchronously; next 4 beats 0xFF,0xFF,0xFF,0x80 with mode=0 -> out_parity=1.
REQ-039 SHALL cover: mode toggled after the first data beat -> result uses the latched initial mode.
